mem_arbiter: RTL

//  Shares one single-port, variable-latency memory bus between the fetch-stage

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one variable-latency memory bus between the fetch (I) and
//            data (D) ports, with bounded D-over-I starvation and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          bus_err
);

  localparam int            c_SW       = $clog2(MAX_DSTREAK + 1);
  localparam logic [c_SW-1:0] c_MAX    = c_SW'(MAX_DSTREAK);
  localparam logic [7:0]    c_TIMEOUT  = 8'(TIMEOUT);
  localparam logic [DW-1:0] c_ERR_DATA = DW'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [c_SW-1:0] r_dStreak;
  logic [7:0]      r_tcnt;
  logic [7:0]      w_tcntInc;
  logic            r_grantIsD;
  logic            w_grantD;
  logic            w_grantI;
  logic            w_done;
  logic            w_timeout;
  logic [DW-1:0]   w_loadData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_grantD    = 1'b0;
    w_grantI    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_tcntInc   = r_tcnt + 8'd1;
    case (r_state)
      IDLE: begin
        // D normally wins; I is forced through once the D streak saturates
        if (d_req && (!i_req || r_dStreak != c_MAX)) begin
          w_grantD    = 1'b1;
          w_nextState = DBUSY;
        end else if (i_req) begin
          w_grantI    = 1'b1;
          w_nextState = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_nextState = RESP;
        end else if (w_tcntInc == c_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_loadData = w_done ? mem_rdata : c_ERR_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
      r_dStreak  <= '0;
      r_tcnt     <= '0;
      r_grantIsD <= 1'b0;
    end else begin
      if (w_grantD) begin
        mem_req    <= 1'b1;
        mem_we     <= d_we;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        r_grantIsD <= 1'b1;
        if (!i_req)
          r_dStreak <= '0;
        else if (r_dStreak != c_MAX)
          r_dStreak <= r_dStreak + c_SW'(1);
      end
      if (w_grantI) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= i_addr;
        r_grantIsD <= 1'b0;
        r_dStreak  <= '0;
      end
      if (w_done || w_timeout) begin
        mem_req <= 1'b0;
        r_tcnt  <= '0;
        // Stores leave the read-data registers untouched
        if (!mem_we) begin
          if (r_state == DBUSY) d_rdata <= w_loadData;
          else                  i_rdata <= w_loadData;
        end
      end else if (r_state == IBUSY || r_state == DBUSY) begin
        r_tcnt <= w_tcntInc;
      end
      if (w_timeout) bus_err <= 1'b1;
    end
  end

  assign i_ready = (r_state == RESP) && !r_grantIsD;
  assign d_ready = (r_state == RESP) &&  r_grantIsD;
  assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

`default_nettype wire
